// File: rtl/apb_cmd_master_pkg.sv
// Shared definitions for the command-FIFO to APB bridge: state encoding,
// command word field positions and the timeout response value.
package apb_cmd_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam int unsigned CNT_W = 10;

  // Timeout response is {err=1, data=all ones}
  localparam logic TO_RSP_ERR  = 1'b1;
  localparam logic TO_RSP_FILL = 1'b1;

  // Command word layout: {write, addr, wdata}
  function automatic int unsigned cmd_wr_bit(input int unsigned cmd_w);
    return cmd_w - 1;
  endfunction

  function automatic int unsigned cmd_addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/apb_cmd_master_if.sv
// Bundle of the command FIFO read side, APB master bus, response FIFO write
// side and status; master modport is the bridge view.
interface apb_cmd_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                     fifo_empty;
  logic [ADDR_W+DATA_W:0]   fifo_rdata;
  logic                     fifo_rinc;
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDR_W-1:0]        paddr;
  logic [DATA_W-1:0]        pwdata;
  logic [DATA_W-1:0]        prdata;
  logic                     pready;
  logic                     pslverr;
  logic                     rsp_full;
  logic                     rsp_winc;
  logic [DATA_W:0]          rsp_wdata;
  logic                     busy;

  modport master (
    input  fifo_empty, fifo_rdata, prdata, pready, pslverr, rsp_full,
    output fifo_rinc, psel, penable, pwrite, paddr, pwdata,
           rsp_winc, rsp_wdata, busy
  );

  modport slave (
    output fifo_empty, fifo_rdata, prdata, pready, pslverr, rsp_full,
    input  fifo_rinc, psel, penable, pwrite, paddr, pwdata,
           rsp_winc, rsp_wdata, busy
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; flags the cycle in which the count would reach
// TIMEOUT while the slave is still not ready.
module apb_timeout_cnt
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic r_clk,
  input  logic r_rstn,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)      cnt_d = '0;
    else if (count_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = count_i && (cnt_q == LIMIT);

endmodule

// File: rtl/apb_cmd_master.sv
// Pops {write, addr, wdata} commands from a FIFO, runs one APB transfer per
// command and pushes a {err, data} response, with an ACCESS-phase timeout.
module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CMD_W   = 1 + ADDR_W + DATA_W
) (
  input  logic             r_clk,
  input  logic             r_rstn,
  apb_cmd_master_if.master bus
);

  localparam int unsigned WR_BIT   = cmd_wr_bit(CMD_W);
  localparam int unsigned ADDR_LSB = cmd_addr_lsb(DATA_W);

  state_e              state_q, state_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                busy_q, busy_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W:0]     rsp_q, rsp_d;
  logic [DATA_W-1:0]   rdata_sel;
  logic                pop;
  logic                acc_wait;
  logic                expired;

  assign pop      = r_rstn && (state_q == IDLE) && !bus.fifo_empty;
  assign acc_wait = (state_q == ACCESS) && !bus.pready;

  apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .r_clk     (r_clk),
    .r_rstn    (r_rstn),
    .clear_i   (pop),
    .count_i   (acc_wait),
    .expired_o (expired)
  );

  assign rdata_sel = pwrite_q ? '0 : bus.prdata;

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rsp_d    = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          pwrite_d = bus.fifo_rdata[WR_BIT];
          paddr_d  = bus.fifo_rdata[ADDR_LSB +: ADDR_W];
          pwdata_d = bus.fifo_rdata[DATA_W-1:0];
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          rsp_d   = {bus.pslverr, rdata_sel};
          state_d = RESP;
        end else if (expired) begin
          rsp_d   = {TO_RSP_ERR, {DATA_W{TO_RSP_FILL}}};
          state_d = RESP;
        end
      end
      RESP: if (!bus.rsp_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Bus strobes are registered from the next state so they line up with it
    psel_d    = (state_d == SETUP) || (state_d == ACCESS);
    penable_d = (state_d == ACCESS);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge r_clk or negedge r_rstn) begin
    if (!r_rstn) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      busy_q    <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rsp_q     <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      busy_q    <= busy_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rsp_q     <= rsp_d;
    end
  end

  assign bus.fifo_rinc = pop;
  assign bus.rsp_winc  = (state_q == RESP) && !bus.rsp_full;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.busy      = busy_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_wdata = rsp_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Transaction-level bench for apb_cmd_master: commands carry their planned
// slave behaviour, and expected bus timing/responses follow from that plan.
module tb_apb_cmd_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            waits;
  } cmd_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  apb_cmd_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .r_clk  (clk),
    .r_rstn (rstn),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  cmd_t          cmd_q[$];
  cmd_t          cur;
  logic          active = 1'b0;
  int            cyc = 0, pop_cyc = 0, acc_len = 0, due = 0;
  logic [DW:0]   exp_rsp = '0;
  int            full_lo = 0, full_hi = 0, stall_next = 0;
  logic          bp_en = 1'b0;
  int            pops[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic cmd_t mk(input logic wr, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                              input logic err, input int waits);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.wdata = wdata; c.rdata = rdata; c.err = err; c.waits = waits;
    return c;
  endfunction

  task automatic drive_fifo();
    bus.fifo_empty = (cmd_q.size() == 0);
    if (cmd_q.size() != 0) bus.fifo_rdata = {cmd_q[0].wr, cmd_q[0].addr, cmd_q[0].wdata};
    else                   bus.fifo_rdata = {1'($urandom), 32'($urandom), 32'($urandom)};
  endtask

  // Expected behaviour derived from the command's plan: one SETUP cycle,
  // min(waits+1, TO) ACCESS cycles, then RESP until rsp_full is low.
  task automatic observe();
    logic e_psel, e_pen, e_busy, e_rinc, e_winc;
    e_psel = active && cyc >= pop_cyc + 1 && cyc <= pop_cyc + 1 + acc_len;
    e_pen  = active && cyc >= pop_cyc + 2 && cyc <= pop_cyc + 1 + acc_len;
    e_busy = active && cyc >= pop_cyc + 1;
    e_winc = active && cyc >= due && !bus.rsp_full;
    e_rinc = !active && cmd_q.size() > 0;
    check("fifo_rinc", 64'(bus.fifo_rinc), 64'(e_rinc));
    check("psel",      64'(bus.psel),      64'(e_psel));
    check("penable",   64'(bus.penable),   64'(e_pen));
    check("busy",      64'(bus.busy),      64'(e_busy));
    check("rsp_winc",  64'(bus.rsp_winc),  64'(e_winc));
    if (e_psel) begin
      check("pwrite", 64'(bus.pwrite), 64'(cur.wr));
      check("paddr",  64'(bus.paddr),  64'(cur.addr));
      check("pwdata", 64'(bus.pwdata), 64'(cur.wdata));
    end
    if (active && cyc >= due) check("rsp_wdata", 64'(bus.rsp_wdata), 64'(exp_rsp));
    if (e_rinc) begin
      cur     = cmd_q.pop_front();
      active  = 1'b1;
      pop_cyc = cyc;
      pops.push_back(cyc);
      acc_len = (cur.waits < int'(TO)) ? cur.waits + 1 : int'(TO);
      due     = pop_cyc + 2 + acc_len;
      if (cur.waits >= int'(TO)) exp_rsp = {1'b1, {DW{1'b1}}};
      else                       exp_rsp = {cur.err, cur.wr ? DW'(0) : cur.rdata};
      if (stall_next > 0) begin
        full_lo    = due;
        full_hi    = due + stall_next;
        stall_next = 0;
      end
    end else if (e_winc) begin
      active = 1'b0;
    end
  endtask

  // One clock: drive inputs just after posedge, check at negedge.
  task automatic step();
    logic in_acc;
    drive_fifo();
    in_acc = active && cyc >= pop_cyc + 2 && cyc <= pop_cyc + 1 + acc_len;
    if (in_acc) bus.pready = ((cyc - pop_cyc - 2) == cur.waits);
    else        bus.pready = 1'($urandom);
    bus.pslverr  = (in_acc && bus.pready) ? cur.err   : 1'($urandom);
    bus.prdata   = (in_acc && bus.pready) ? cur.rdata : $urandom;
    bus.rsp_full = (cyc >= full_lo && cyc < full_hi) || (bp_en && $urandom_range(0, 2) == 0);
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && (active || cmd_q.size() > 0); i++) step();
    check("drain_bound", 64'(active || cmd_q.size() > 0), 64'(0));
    step();
  endtask

  initial begin
    bus.fifo_empty = 1'b0;
    bus.fifo_rdata = '1;
    bus.prdata     = '1;
    bus.pready     = 1'b1;
    bus.pslverr    = 1'b1;
    bus.rsp_full   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_psel",      64'(bus.psel),      64'(0));
    check("rst_penable",   64'(bus.penable),   64'(0));
    check("rst_pwrite",    64'(bus.pwrite),    64'(0));
    check("rst_paddr",     64'(bus.paddr),     64'(0));
    check("rst_pwdata",    64'(bus.pwdata),    64'(0));
    check("rst_rsp_wdata", 64'(bus.rsp_wdata), 64'(0));
    check("rst_fifo_rinc", 64'(bus.fifo_rinc), 64'(0));
    check("rst_rsp_winc",  64'(bus.rsp_winc),  64'(0));
    check("rst_busy",      64'(bus.busy),      64'(0));
    rstn = 1'b1;
    repeat (2) step();

    // Single zero-wait read
    cmd_q.push_back(mk(1'b0, 32'h40, 32'hDEAD_BEEF, 32'hA5A5_0001, 1'b0, 0));
    drain();
    // Write with three wait states
    cmd_q.push_back(mk(1'b1, 32'h80, 32'h1234, 32'h5555_AAAA, 1'b0, 3));
    drain();
    // Slave error on read
    cmd_q.push_back(mk(1'b0, 32'h100, 32'h0, 32'h0BAD_F00D, 1'b1, 0));
    drain();
    // Timeout, then a normal command, then the last-cycle-ready boundary
    cmd_q.push_back(mk(1'b0, 32'h200, 32'h0, 32'h1111_2222, 1'b0, 50));
    cmd_q.push_back(mk(1'b0, 32'h204, 32'h0, 32'h3333_4444, 1'b0, 0));
    cmd_q.push_back(mk(1'b0, 32'h208, 32'h0, 32'h5555_6666, 1'b1, int'(TO) - 1));
    drain();
    // Response backpressure for 5 cycles
    stall_next = 5;
    cmd_q.push_back(mk(1'b1, 32'h300, 32'hCAFE, 32'h0, 1'b0, 0));
    drain();
    // Three back-to-back commands: pops four cycles apart
    pops.delete();
    cmd_q.push_back(mk(1'b0, 32'h400, 32'h0, 32'h0000_0001, 1'b0, 0));
    cmd_q.push_back(mk(1'b1, 32'h404, 32'h0000_0002, 32'h0, 1'b1, 0));
    cmd_q.push_back(mk(1'b0, 32'h408, 32'h0, 32'h0000_0003, 1'b0, 0));
    drain();
    check("pop_gap_1", 64'(pops[1] - pops[0]), 64'(4));
    check("pop_gap_2", 64'(pops[2] - pops[1]), 64'(4));

    // Reset during ACCESS discards the in-flight command
    cmd_q.push_back(mk(1'b0, 32'h500, 32'h0, 32'h7777_7777, 1'b0, 5));
    cmd_q.push_back(mk(1'b0, 32'h504, 32'h0, 32'h8888_8888, 1'b0, 0));
    for (int i = 0; i < 20 && !(active && cyc >= pop_cyc + 3); i++) step();
    check("reach_access", 64'(active && cyc >= pop_cyc + 3), 64'(1));
    drive_fifo();
    bus.rsp_full = 1'b0;
    rstn = 1'b0;
    #1;
    check("rstmid_psel",     64'(bus.psel),      64'(0));
    check("rstmid_penable",  64'(bus.penable),   64'(0));
    check("rstmid_busy",     64'(bus.busy),      64'(0));
    check("rstmid_rinc",     64'(bus.fifo_rinc), 64'(0));
    check("rstmid_winc",     64'(bus.rsp_winc),  64'(0));
    check("rstmid_rsp",      64'(bus.rsp_wdata), 64'(0));
    active = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc += 2;
    drain();

    // Randomised traffic with random backpressure and bus noise
    bp_en = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int n = 0; n < 10; n++)
        cmd_q.push_back(mk(1'($urandom), $urandom, $urandom, $urandom, 1'($urandom),
                           int'($urandom_range(0, 11))));
      drain();
      repeat ($urandom_range(0, 3)) step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 Parameters (name, default, meaning); the module SHALL expose exactly these:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 255, maximum ACCESS cycles waiting for pready (1..1023)
- CMD_W, 1+ADDR_W+DATA_W, derived command word width
REQ-002 Ports (name, direction, width, meaning); the module SHALL expose exactly these:
- r_clk, in, 1, read-domain clock
- r_rstn, in, 1, asynchronous active-low reset
- fifo_empty, in, 1, command FIFO empty flag
- fifo_rdata, in, CMD_W, head command {write, addr, wdata}; valid whenever fifo_empty=0
- fifo_rinc, out, 1, command FIFO pop strobe
- psel, out, 1, APB select
- penable, out, 1, APB enable
- pwrite, out, 1, APB direction
- paddr, out, ADDR_W, APB address
- pwdata, out, DATA_W, APB write data
- prdata, in, DATA_W, APB read data
- pready, in, 1, APB ready
- pslverr, in, 1, APB slave error
- rsp_full, in, 1, response FIFO full flag
- rsp_winc, out, 1, response FIFO push strobe
- rsp_wdata, out, DATA_W+1, response word {err, data}
- busy, out, 1, high whenever state is not IDLE

Function
REQ-003 FSM states SHALL be IDLE, SETUP, ACCESS and RESP.
REQ-004 IDLE with fifo_empty=0: in that cycle, fifo_rinc SHALL be 1 for exactly one cycle, fifo_rdata SHALL be latched into pwrite/paddr/pwdata, and the next state SHALL be SETUP.
REQ-005 fifo_rinc SHALL never be asserted outside IDLE or while fifo_empty=1.
REQ-006 SETUP: psel=1, penable=0; the next state SHALL be ACCESS unconditionally.
REQ-007 ACCESS: psel=1, penable=1, and pwrite/paddr/pwdata SHALL be held stable.
REQ-008 ACCESS with pready=1: the block SHALL capture {pslverr, prdata}, or {pslverr, 0} for writes, into the response register and go to RESP.
REQ-009 ACCESS timeout: a 10-bit counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0; when it reaches TIMEOUT, the response SHALL be {1, all-ones}, the next state SHALL be RESP, and psel/penable SHALL drop.
REQ-010 RESP: psel=0, penable=0; rsp_winc SHALL equal !rsp_full; when the push occurs, the next state SHALL be IDLE, otherwise the block SHALL stay in RESP with rsp_wdata held.
REQ-011 Every popped command SHALL produce exactly one response, in pop order.
REQ-012 Minimum latency (zero-wait slave, rsp_full=0):
- fifo_rinc at cycle 0
- psel at cycle 1
- penable at cycle 2
- rsp_winc at cycle 3
- next pop at cycle 4
REQ-013 pready or pslverr sampled outside ACCESS SHALL be ignored.
REQ-014 rsp_full asserted during SETUP or ACCESS SHALL NOT stall the APB transfer; backpressure SHALL apply only in RESP.
REQ-015 All outputs except fifo_rinc and rsp_winc SHALL be registered; fifo_rinc and rsp_winc SHALL be decoded from state and the input flags only.

Reset
REQ-016 On r_rstn=0 the block SHALL enter IDLE asynchronously.
REQ-017 Reset values SHALL be:
- psel=0, penable=0, pwrite=0
- paddr=0, pwdata=0
- rsp_wdata=0
- fifo_rinc=0, rsp_winc=0
- busy=0
- timeout counter=0
REQ-018 Reset mid-transfer SHALL drop psel/penable immediately; the in-flight command SHALL be discarded with no response.

Structure
REQ-019 The shared bridge package SHALL hold:
- the state encoding (IDLE=0, SETUP=1, ACCESS=2, RESP=3)
- the command field offsets: write bit at CMD_W-1, addr above wdata
- the timeout response constant
REQ-020 The block SHALL be one module plus one sub-module, apb_timeout_cnt, containing the counter and the compare against TIMEOUT.

Verification
REQ-021 Single read: FIFO holds {0, 0x40, x}, zero-wait slave returns prdata=0xA5A5_0001 -> psel at cycle 1, penable at cycle 2, rsp_wdata={0, 0xA5A50001} with rsp_winc at cycle 3.
REQ-022 Write with 3 wait states: {1, 0x80, 0x1234} -> penable held for 4 cycles with paddr/pwdata stable, then response {0, 0}.
REQ-023 Slave error: read to 0x100 with pslverr=1 -> response {1, prdata}.
REQ-024 Timeout: TIMEOUT=8, pready held 0 -> after 8 ACCESS cycles, response {1, 0xFFFFFFFF}; the next command is then processed normally.
REQ-025 Backpressure and order: rsp_full=1 for 5 cycles in RESP -> rsp_winc=0 and no fifo_rinc; then release -> three back-to-back commands produce three in-order responses, with pops at cycles 0, 4 and 8.
REQ-026 Reset in ACCESS: r_rstn pulsed low -> psel/penable 0 in the same cycle, busy=0, and no response pushed.
